mem_write_checker: RTL
======================

# mem_write_checker

Synthesizable, parametrised data-memory write checker for the 16-bit single-cycle computer. It taps the processor's data-memory bus (`memwrite`, `dataadr`, `writedata`) and compares observed stores against a loaded table of up to `DEPTH` expected (address, data) pairs. It reports pass, fail or timeout, with ordered or unordered matching, so programs self-check in simulation and on hardware without testbench hierarchy probes.

## Interface
Parameters:
- `N`, 16, data width of `writedata`/`exp_data`/`err_data`
- `A`, 16, address width of `dataadr`/`exp_addr`/`err_addr`
- `DEPTH`, 4, number of expected-write entries (≥1); `IW = $clog2(DEPTH)` (min 1)
- `ORDERED`, 0, 1 = entries must be matched in ascending index order; 0 = any order
- `TIMEOUT`, 1024, max cycles in ARMED before failing (≥2)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `memwrite`  in  1  processor store strobe
- `dataadr`  in  A  store address
- `writedata`  in  N  store data
- `exp_we`  in  1  load table entry (IDLE only)
- `exp_idx`  in  IW  entry index for load
- `exp_addr`  in  A  expected address
- `exp_data`  in  N  expected data
- `start`  in  1  arm checker (IDLE only)
- `clear`  in  1  invalidate table, return to IDLE
- `done`  out  1  in PASS or FAIL
- `pass`  out  1  all valid entries matched
- `fail`  out  1  mismatch or timeout
- `timeout_flag`  out  1  fail caused by timeout
- `match_count`  out  IW+1  entries matched so far
- `err_addr`  out  A  address of failing store (0 on timeout)
- `err_data`  out  N  data of failing store (0 on timeout)

## Operation
- States: IDLE → ARMED → PASS | FAIL. PASS/FAIL hold until `clear` (→ IDLE, table invalidated) or reset.
- IDLE: `exp_we` writes entry `exp_idx` and sets its valid bit; rewriting an index overwrites it. `start` → ARMED; clears matched bits, `match_count`, timeout counter. `start` with zero valid entries → PASS directly.
- `exp_we`/`start` outside IDLE: ignored. `clear` has priority over all other inputs in any state.
- ARMED, on `memwrite`=1, candidates = valid, unmatched entries (ORDERED=1: only the lowest-index valid unmatched entry):
  - address and data equal a candidate → mark matched (unordered: lowest such index only), `match_count` +1.
  - otherwise ignored, unless strict (see Configuration).
- Stores to addresses absent from the table, or to already-matched entries, never fail.
- All valid entries matched → PASS.
- Timeout counter increments each ARMED cycle; counter reaching `TIMEOUT-1` without completion → FAIL, `timeout_flag`=1.
- `memwrite`=0 cycles never change match state.

## Timing
- Reset (`reset`=0 at posedge): state IDLE, table invalid, all outputs 0.
- Stores sampled at posedge; `match_count` updates the following cycle.
- `pass`/`done` assert the cycle after the posedge sampling the final matching store.
- `fail`/`done` assert the cycle after the offending store or the timeout edge.
- Final match and timeout on the same edge → PASS wins. Strict mismatch and a match of another entry on the same edge is impossible (one store per cycle).
- Store on the same edge as `start` is not checked. First checked store is the edge after `start`.
- Reset or `clear` mid-ARMED: aborts immediately, no pass/fail pulse.

## Configuration
- `MEM_WRITE_CHECKER_STRICT_EN` defined: in ARMED, a store whose address equals a candidate's address but whose data differs → FAIL, `err_addr`/`err_data` latch that store. With ORDERED=1, a store exactly matching a valid unmatched non-candidate entry (out of order) → FAIL as well.
- Not defined: such stores are ignored. FAIL only by timeout. `err_addr`/`err_data` stay 0.

## Test plan
- Reset → all outputs 0. Load entry 0 = (84, 0x0096), `start`, store 84/0x0096 three cycles later → `pass`=1, `done`=1 next cycle, `match_count`=1.
- Unordered, entries 0=(80,0x0007), 1=(84,0x0096). Stores 84/0x0096 then 80/0x0007 → PASS. Same with ORDERED=1 and STRICT undefined → first store ignored, `match_count`=1, then TIMEOUT → `fail`, `timeout_flag`=1.
- STRICT defined, entry (84,0x0096), store 84/0x0095 → `fail`=1, `err_addr`=84, `err_data`=0x0095, `timeout_flag`=0.
- TIMEOUT=8, armed, no stores → `fail`+`timeout_flag` exactly 8 cycles after arming edge. Last match on the timeout edge → `pass`.
- Reset low and `clear` each applied mid-ARMED with 1 of 2 matched → IDLE, `match_count`=0, no `done`. `exp_we` while ARMED → table unchanged.
- Duplicate entries 0,1 = (84,0x0096), unordered, one store → `match_count`=1, no pass; second identical store → PASS.

Source files
------------

// File: rtl/mem_write_checker.sv
// Data-memory store checker: matches observed stores against a loaded (address, data) table.
// Define MEM_WRITE_CHECKER_STRICT_EN to fail on wrong-data or out-of-order stores.
module mem_write_checker #(
    parameter int N       = 16,
    parameter int A       = 16,
    parameter int DEPTH   = 4,
    parameter int ORDERED = 0,
    parameter int TIMEOUT = 1024,
    parameter int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [A-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [A-1:0]  exp_addr,
    input  logic [N-1:0]  exp_data,
    input  logic          start,
    input  logic          clear,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout_flag,
    output logic [IW:0]   match_count,
    output logic [A-1:0]  err_addr,
    output logic [N-1:0]  err_data
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

    state_t           state_q, state_d;
    logic [A-1:0]     addr_q [DEPTH];
    logic [A-1:0]     addr_d [DEPTH];
    logic [N-1:0]     data_q [DEPTH];
    logic [N-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, matched_q, matched_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [IW:0]      mcnt_q, mcnt_d;
    logic             tflag_q, tflag_d;
    logic [A-1:0]     eaddr_q, eaddr_d;
    logic [N-1:0]     edata_q, edata_d;

    logic [DEPTH-1:0] open_w, cand_w, hit_w, pick_w;
    logic             cand_found, pick_found, strict_err;

    // Ordered mode narrows the candidate set to the lowest open entry;
    // a hit always claims only the lowest matching index.
    always_comb begin
        open_w     = valid_q & ~matched_q;
        cand_w     = '0;
        cand_found = 1'b0;
        hit_w      = '0;
        pick_w     = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (open_w[i] && (ORDERED == 0 || !cand_found)) begin
                cand_w[i]  = 1'b1;
                cand_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_w[i] = cand_w[i] && (dataadr == addr_q[i]) && (writedata == data_q[i]);
            if (hit_w[i] && !pick_found) begin
                pick_w[i]  = 1'b1;
                pick_found = 1'b1;
            end
        end
    end

`ifdef MEM_WRITE_CHECKER_STRICT_EN
    logic [DEPTH-1:0] addr_only_w, ooo_w;

    always_comb begin
        addr_only_w = '0;
        ooo_w       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_only_w[i] = cand_w[i] && (dataadr == addr_q[i]) && (writedata != data_q[i]);
            ooo_w[i]       = open_w[i] && !cand_w[i] && (dataadr == addr_q[i])
                             && (writedata == data_q[i]);
        end
        strict_err = !pick_found && ((|addr_only_w) || (|ooo_w));
    end
`else
    always_comb strict_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        matched_d = matched_q;
        tcnt_d    = tcnt_q;
        mcnt_d    = mcnt_q;
        tflag_d   = tflag_q;
        eaddr_d   = eaddr_q;
        edata_d   = edata_q;
        if (clear) begin
            state_d   = S_IDLE;
            valid_d   = '0;
            matched_d = '0;
            tcnt_d    = '0;
            mcnt_d    = '0;
            tflag_d   = 1'b0;
            eaddr_d   = '0;
            edata_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (exp_we && exp_idx == IW'(i)) begin
                            addr_d[i]  = exp_addr;
                            data_d[i]  = exp_data;
                            valid_d[i] = 1'b1;
                        end
                    end
                    if (start) begin
                        matched_d = '0;
                        tcnt_d    = '0;
                        mcnt_d    = '0;
                        tflag_d   = 1'b0;
                        eaddr_d   = '0;
                        edata_d   = '0;
                        state_d   = (valid_d == '0) ? S_PASS : S_ARMED;
                    end
                end
                S_ARMED: begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (memwrite && strict_err) begin
                        state_d = S_FAIL;
                        eaddr_d = dataadr;
                        edata_d = writedata;
                    end else begin
                        if (memwrite && pick_found) begin
                            matched_d = matched_q | pick_w;
                            mcnt_d    = mcnt_q + (IW+1)'(1);
                        end
                        // Completion is tested before timeout so a final match on the timeout edge passes.
                        if (matched_d == valid_q) begin
                            state_d = S_PASS;
                        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                            state_d = S_FAIL;
                            tflag_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            matched_q <= '0;
            tcnt_q    <= '0;
            mcnt_q    <= '0;
            tflag_q   <= 1'b0;
            eaddr_q   <= '0;
            edata_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            matched_q <= matched_d;
            tcnt_q    <= tcnt_d;
            mcnt_q    <= mcnt_d;
            tflag_q   <= tflag_d;
            eaddr_q   <= eaddr_d;
            edata_q   <= edata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign pass         = (state_q == S_PASS);
    assign fail         = (state_q == S_FAIL);
    assign done         = pass | fail;
    assign timeout_flag = tflag_q;
    assign match_count  = mcnt_q;
    assign err_addr     = eaddr_q;
    assign err_data     = edata_q;
endmodule
